// File: rtl/inst_decode_if.sv
// Bundle between fetch/write-back (master) and the instruction-decode stage (slave).
interface inst_decode_if #(
  parameter int DATA_W = 16
);
  logic [31:0]       IR;
  logic [15:0]       NPC;
  logic              IR_VALID;
  logic              WB_EN;
  logic [4:0]        WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] IMM;
  logic [15:0]       NPC_OUT;
  logic [5:0]        OPCODE;
  logic [5:0]        FUNCT;
  logic [4:0]        DEST;
  logic              DEC_VALID;
  logic              BUSY;
  logic [1:0]        ESTADO;

  modport master (
    output IR, NPC, IR_VALID, WB_EN, WB_ADDR, WB_DATA,
    input  A, B, IMM, NPC_OUT, OPCODE, FUNCT, DEST, DEC_VALID, BUSY, ESTADO
  );

  modport slave (
    input  IR, NPC, IR_VALID, WB_EN, WB_ADDR, WB_DATA,
    output A, B, IMM, NPC_OUT, OPCODE, FUNCT, DEST, DEC_VALID, BUSY, ESTADO
  );
endinterface

// File: rtl/inst_decode.sv
// Multicycle decode stage: latches IR/NPC, decodes fields, owns the 32-entry register file.
// Define INST_DECODE_BYPASS_EN to forward a same-edge write-back into A/B at the READ edge.
module inst_decode #(
  parameter int DATA_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  inst_decode_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              latch_en;
  logic              decode_en;
  logic              read_en;
  logic [31:0]       ir_q;
  logic [15:0]       npc_q;
  logic [DATA_W-1:0] rf [32];
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              unused_shamt;

  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign unused_shamt = ^ir_q[10:6];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    decode_en = 1'b0;
    read_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.IR_VALID) begin
          latch_en = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        decode_en = 1'b1;
        state_d   = READ;
      end
      READ: begin
        read_en = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DEC_VALID = (state_q == DONE);
  assign bus.ESTADO    = state_q;

  // Write-back port is live in every state; r0 is never stored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.WB_EN && (bus.WB_ADDR != 5'd0)) begin
      rf[bus.WB_ADDR] <= bus.WB_DATA;
    end
  end

`ifdef INST_DECODE_BYPASS_EN
  assign fwd_a = bus.WB_EN && (bus.WB_ADDR == rs);
  assign fwd_b = bus.WB_EN && (bus.WB_ADDR == rt);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // r0 check comes first so a write-back aimed at r0 can never leak through the bypass.
  assign rd_a = (rs == 5'd0) ? '0 : (fwd_a ? bus.WB_DATA : rf[rs]);
  assign rd_b = (rt == 5'd0) ? '0 : (fwd_b ? bus.WB_DATA : rf[rt]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir_q        <= '0;
      npc_q       <= '0;
      bus.OPCODE  <= '0;
      bus.FUNCT   <= '0;
      bus.DEST    <= '0;
      bus.IMM     <= '0;
      bus.NPC_OUT <= '0;
      bus.A       <= '0;
      bus.B       <= '0;
    end else begin
      if (latch_en) begin
        ir_q  <= bus.IR;
        npc_q <= bus.NPC;
      end
      if (decode_en) begin
        bus.OPCODE  <= ir_q[31:26];
        bus.FUNCT   <= ir_q[5:0];
        bus.DEST    <= (ir_q[31:26] == 6'd0) ? ir_q[15:11] : ir_q[20:16];
        bus.IMM     <= DATA_W'($signed(ir_q[15:0]));
        bus.NPC_OUT <= npc_q;
      end
      if (read_en) begin
        bus.A <= rd_a;
        bus.B <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: vector table, hand sequences and random decodes
// against a register-file model held in a plain array.
module tb_inst_decode;

  localparam int DATA_W = 16;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  int   dv_count;
  logic [15:0] rf_m [32];

  inst_decode_if #(.DATA_W(DATA_W)) bus ();

  inst_decode #(.DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count DEC_VALID cycles a little after each falling edge, away from both edges.
  always @(negedge CLK) begin
    #2;
    if (bus.DEC_VALID) dv_count++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] ir;
    logic [15:0] npc;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) rf_m[i] = 16'h0000;
  endtask

  task automatic wbWrite(input logic [4:0] addr, input logic [15:0] data);
    bus.WB_EN   = 1'b1;
    bus.WB_ADDR = addr;
    bus.WB_DATA = data;
    @(posedge CLK);
    @(negedge CLK);
    bus.WB_EN = 1'b0;
    if (addr != 5'd0) rf_m[addr] = data;
  endtask

  // Full decode from IDLE, with an optional write-back on the READ edge; called at a negedge.
  task automatic applyStimulus(input logic [31:0] ir, input logic [15:0] npc,
                               input logic wb_en, input logic [4:0] wb_addr,
                               input logic [15:0] wb_data);
    int unsigned opc, rs, rt, rd, fn;
    logic [15:0] exp_a, exp_b;
    int dv_before;
    opc = ir / (2 ** 26);
    rs  = (ir / (2 ** 21)) % 32;
    rt  = (ir / (2 ** 16)) % 32;
    rd  = (ir / (2 ** 11)) % 32;
    fn  = ir % 64;
    dv_before = dv_count;

    bus.IR       = ir;
    bus.NPC      = npc;
    bus.IR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.IR_VALID = 1'b0;
    checkOutput("estado_decode", 32'(bus.ESTADO), 32'd1);
    checkOutput("busy_decode", 32'(bus.BUSY), 32'd1);

    @(posedge CLK);
    @(negedge CLK);
    checkOutput("opcode", 32'(bus.OPCODE), opc);
    checkOutput("funct", 32'(bus.FUNCT), fn);
    checkOutput("dest", 32'(bus.DEST), (opc == 0) ? rd : rt);
    checkOutput("imm", 32'(bus.IMM), ir % 65536);
    checkOutput("npc_out", 32'(bus.NPC_OUT), 32'(npc));

    exp_a = (rs == 0) ? 16'h0 : rf_m[rs];
    exp_b = (rt == 0) ? 16'h0 : rf_m[rt];
`ifdef INST_DECODE_BYPASS_EN
    if (wb_en && (wb_addr == rs) && (rs != 0)) exp_a = wb_data;
    if (wb_en && (wb_addr == rt) && (rt != 0)) exp_b = wb_data;
`endif
    bus.WB_EN   = wb_en;
    bus.WB_ADDR = wb_addr;
    bus.WB_DATA = wb_data;
    @(posedge CLK);
    @(negedge CLK);
    bus.WB_EN = 1'b0;
    if (wb_en && (wb_addr != 5'd0)) rf_m[wb_addr] = wb_data;
    checkOutput("a", 32'(bus.A), 32'(exp_a));
    checkOutput("b", 32'(bus.B), 32'(exp_b));
    checkOutput("dec_valid_high", 32'(bus.DEC_VALID), 32'd1);

    @(posedge CLK);
    @(negedge CLK);
    checkOutput("dec_valid_low", 32'(bus.DEC_VALID), 32'd0);
    checkOutput("estado_idle", 32'(bus.ESTADO), 32'd0);
    checkOutput("dec_valid_once", 32'(dv_count - dv_before), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"}, 32'(bus.A), 32'd0);
    checkOutput({tag, "_b"}, 32'(bus.B), 32'd0);
    checkOutput({tag, "_imm"}, 32'(bus.IMM), 32'd0);
    checkOutput({tag, "_npc"}, 32'(bus.NPC_OUT), 32'd0);
    checkOutput({tag, "_op"}, 32'(bus.OPCODE), 32'd0);
    checkOutput({tag, "_fn"}, 32'(bus.FUNCT), 32'd0);
    checkOutput({tag, "_dest"}, 32'(bus.DEST), 32'd0);
    checkOutput({tag, "_dv"}, 32'(bus.DEC_VALID), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    checkOutput({tag, "_estado"}, 32'(bus.ESTADO), 32'd0);
  endtask

  initial begin
    int dv_before;
    logic [31:0] rir;
    logic [4:0]  waddr;
    total    = 0;
    bad      = 0;
    dv_count = 0;
    clearModel();

    vecs[0] = '{32'h00221820, 16'h0005, 6'h00, 6'h20, 5'd3,  16'h1820};
    vecs[1] = '{32'h8C22FFFC, 16'h0010, 6'h23, 6'h3C, 5'd2,  16'hFFFC};
    vecs[2] = '{32'h20220007, 16'h0011, 6'h08, 6'h07, 5'd2,  16'h0007};
    vecs[3] = '{32'h03E0F809, 16'hABCD, 6'h00, 6'h09, 5'd31, 16'hF809};
    vecs[4] = '{32'hFFFFFFFF, 16'hFFFF, 6'h3F, 6'h3F, 5'd31, 16'hFFFF};

    RST          = 1'b0;
    bus.IR       = '0;
    bus.NPC      = '0;
    bus.IR_VALID = 1'b0;
    bus.WB_EN    = 1'b0;
    bus.WB_ADDR  = '0;
    bus.WB_DATA  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] first decode from reset");
    applyStimulus(32'h00221820, 16'h0005, 1'b0, 5'd0, 16'h0);

    $display("[TB] vector table");
    wbWrite(5'd1, 16'h1234);
    wbWrite(5'd2, 16'h00FF);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ir, vecs[i].npc, 1'b0, 5'd0, 16'h0);
      checkOutput($sformatf("tbl%0d_op", i), 32'(bus.OPCODE), 32'(vecs[i].op));
      checkOutput($sformatf("tbl%0d_fn", i), 32'(bus.FUNCT), 32'(vecs[i].fn));
      checkOutput($sformatf("tbl%0d_dest", i), 32'(bus.DEST), 32'(vecs[i].dest));
      checkOutput($sformatf("tbl%0d_imm", i), 32'(bus.IMM), 32'(vecs[i].imm));
      checkOutput($sformatf("tbl%0d_npc", i), 32'(bus.NPC_OUT), 32'(vecs[i].npc));
    end
    applyStimulus(32'h00221820, 16'h0006, 1'b0, 5'd0, 16'h0);
    checkOutput("rtype_a_1234", 32'(bus.A), 32'h1234);
    checkOutput("rtype_b_00ff", 32'(bus.B), 32'h00FF);

    $display("[TB] read-edge collision on r1");
    applyStimulus(32'h00221820, 16'h0007, 1'b1, 5'd1, 16'hBEEF);
`ifdef INST_DECODE_BYPASS_EN
    checkOutput("collide_a", 32'(bus.A), 32'hBEEF);
`else
    checkOutput("collide_a", 32'(bus.A), 32'h1234);
`endif
    applyStimulus(32'h00221820, 16'h0008, 1'b0, 5'd0, 16'h0);
    checkOutput("after_collide_a", 32'(bus.A), 32'hBEEF);

    $display("[TB] non-colliding read-edge write and r0");
    applyStimulus(32'h00221820, 16'h0009, 1'b1, 5'd5, 16'h5555);
    checkOutput("noncollide_b", 32'(bus.B), 32'h00FF);
    applyStimulus(32'h00A52820, 16'h000A, 1'b0, 5'd0, 16'h0);
    checkOutput("r5_read", 32'(bus.A), 32'h5555);
    wbWrite(5'd0, 16'hFFFF);
    applyStimulus(32'h00000020, 16'h000B, 1'b1, 5'd0, 16'hAAAA);
    checkOutput("r0_a", 32'(bus.A), 32'h0);
    checkOutput("r0_b", 32'(bus.B), 32'h0);

    $display("[TB] strobe during DECODE is ignored");
    dv_before    = dv_count;
    bus.IR       = 32'h8C22FFFC;
    bus.NPC      = 16'h0042;
    bus.IR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.IR       = 32'hFFFFFFFF;
    bus.NPC      = 16'h7777;
    @(posedge CLK);
    @(negedge CLK);
    bus.IR_VALID = 1'b0;
    checkOutput("ign_op", 32'(bus.OPCODE), 32'h23);
    checkOutput("ign_npc", 32'(bus.NPC_OUT), 32'h0042);
    repeat (5) @(negedge CLK);
    checkOutput("ign_one_pulse", 32'(dv_count - dv_before), 32'd1);
    checkOutput("ign_idle", 32'(bus.ESTADO), 32'd0);

    $display("[TB] random decodes");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) wbWrite(5'($urandom_range(0, 31)), 16'($urandom));
      rir = $urandom;
      case ($urandom_range(0, 2))
        0:       waddr = rir[25:21];
        1:       waddr = rir[20:16];
        default: waddr = 5'($urandom_range(0, 31));
      endcase
      applyStimulus(rir, 16'($urandom), 1'($urandom_range(0, 1)), waddr, 16'($urandom));
    end

    $display("[TB] asynchronous reset during READ");
    dv_before    = dv_count;
    bus.IR       = 32'h00221820;
    bus.NPC      = 16'h0099;
    bus.IR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.IR_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_in_read", 32'(bus.ESTADO), 32'd2);
    #3;
    RST = 1'b0;
    #1;
    checkAllZero("midrst");
    clearModel();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("rst_no_dv", 32'(dv_count - dv_before), 32'd0);
    applyStimulus(32'h00221820, 16'h0001, 1'b0, 5'd0, 16'h0);
    checkOutput("rst_cleared_r1", 32'(bus.A), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
